// File: rtl/rv32_dmem_responder.sv
// Data-memory responder for the MEM stage: valid/ready load/store slave
// on a word-organised RAM with byte enables and load extension.
module rv32_dmem_responder #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_2000,
    parameter int unsigned DEPTH_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_funct3,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);
    localparam int unsigned AW   = $clog2(DEPTH_WORDS);
    localparam logic [31:0] SPAN = 32'(4 * DEPTH_WORDS);

    typedef enum logic [1:0] {IDLE, READ, RESP} state_t;

    state_t          state, state_d;
    logic [31:0]     mem [DEPTH_WORDS];
    logic [31:0]     rd_q;
    logic [1:0]      off_q;
    logic [2:0]      f3_q;
    logic            rsp_valid_d, rsp_err_d;
    logic [31:0]     rsp_rdata_d;
    logic            hs, f3_ok, misalign, in_range, acc_err, ram_we;
    logic [31:0]     offset, wlanes, sh, load_val;
    logic [3:0]      be;
    logic [AW-1:0]   word_idx;

    assign req_ready = (state == IDLE) && !rst;
    assign hs        = req_valid && req_ready;
    // Unsigned subtract: addresses below the base wrap high and fail the range test.
    assign offset    = req_addr - BASE_ADDR;
    assign word_idx  = offset[AW+1:2];
    assign in_range  = offset < SPAN;
    assign misalign  = (req_funct3[1:0] == 2'b01 && req_addr[0]) ||
                       (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00);
    assign acc_err   = !f3_ok || misalign || !in_range;

    always_comb begin
        f3_ok = 1'b0;
        case (req_funct3)
            3'b000, 3'b001, 3'b010: f3_ok = 1'b1;
            3'b100, 3'b101:         f3_ok = !req_we;
            default:                f3_ok = 1'b0;
        endcase
    end

    always_comb begin
        be     = 4'b1111;
        wlanes = req_wdata;
        case (req_funct3[1:0])
            2'b00: begin
                be     = 4'b0001 << req_addr[1:0];
                wlanes = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                be     = 4'b0011 << req_addr[1:0];
                wlanes = {2{req_wdata[15:0]}};
            end
            default: begin
                be     = 4'b1111;
                wlanes = req_wdata;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (ram_we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[word_idx][8*i +: 8] <= wlanes[8*i +: 8];
            end
        end
        if (hs) begin
            rd_q  <= mem[word_idx];
            off_q <= req_addr[1:0];
            f3_q  <= req_funct3;
        end
    end

    assign sh = rd_q >> {off_q, 3'b000};

    always_comb begin
        case (f3_q)
            3'b000:  load_val = {{24{sh[7]}}, sh[7:0]};
            3'b001:  load_val = {{16{sh[15]}}, sh[15:0]};
            3'b100:  load_val = {24'd0, sh[7:0]};
            3'b101:  load_val = {16'd0, sh[15:0]};
            default: load_val = sh;
        endcase
    end

    always_comb begin
        state_d     = state;
        rsp_valid_d = rsp_valid;
        rsp_rdata_d = rsp_rdata;
        rsp_err_d   = rsp_err;
        ram_we      = 1'b0;
        case (state)
            IDLE: begin
                if (hs) begin
                    rsp_rdata_d = 32'd0;
                    rsp_err_d   = acc_err;
                    if (acc_err || req_we) begin
                        ram_we      = !acc_err;
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                    end else begin
                        state_d = READ;
                    end
                end
            end
            READ: begin
                state_d     = RESP;
                rsp_valid_d = 1'b1;
                rsp_rdata_d = load_val;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
        end else begin
            state     <= state_d;
            rsp_valid <= rsp_valid_d;
            rsp_rdata <= rsp_rdata_d;
            rsp_err   <= rsp_err_d;
        end
    end
endmodule

// File: tb/tb_rv32_dmem_responder.sv
// Scoreboard bench for rv32_dmem_responder: byte-array reference model,
// decoupled monitor checking data, latency, stability and req_ready.
module tb_rv32_dmem_responder;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic [2:0]  req_funct3 = 3'd0;
    logic        rsp_ready = 1'b1;
    logic        req_ready, rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;

    rv32_dmem_responder dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_funct3(req_funct3),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          due;
    } exp_t;

    exp_t        sb[$];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    int          outstanding = 0;
    bit          held = 0;
    bit          bp_hold = 0;
    bit          rand_rdy = 0;
    logic [31:0] prev_rdata;
    logic        prev_err;
    logic [7:0]  mb [4096];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    // Byte-level view of the RAM window, relative to 0x2000.
    task automatic model(input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [2:0] f3,
                         output logic [31:0] rd, output logic err);
        logic [31:0] off;
        int          sz;
        logic        legal;
        off   = addr - 32'h0000_2000;
        sz    = 1 << f3[1:0];
        legal = we ? (f3 <= 3'd2)
                   : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        err   = !legal || off >= 32'd4096 || (addr % sz) != 0;
        rd    = 32'd0;
        if (!err) begin
            if (we) begin
                for (int i = 0; i < sz; i++) mb[off+i] = wdata[8*i +: 8];
            end else begin
                for (int i = 0; i < sz; i++) rd[8*i +: 8] = mb[off+i];
                if (!f3[2] && sz < 4 && rd[8*sz-1])
                    rd = rd | (32'hFFFF_FFFF << (8*sz));
            end
        end
    endtask

    task automatic issue(input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [2:0] f3,
                         input bit expect_rsp = 1'b1);
        bit          got;
        logic [31:0] rd;
        logic        e;
        got = 1'b0;
        @(posedge clk);
        #1;
        req_valid  = 1'b1;
        req_we     = we;
        req_addr   = addr;
        req_wdata  = wdata;
        req_funct3 = f3;
        for (int i = 0; i < 300 && !got; i++) begin
            @(negedge clk);
            if (req_ready === 1'b1) got = 1'b1;
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL accept_timeout: got no req_ready expected 1 (addr %h)",
                     addr);
        end else begin
            model(we, addr, wdata, f3, rd, e);
            if (expect_rsp)
                sb.push_back('{rd, e, cyc + ((we || e) ? 1 : 2)});
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_addr  = $urandom;
        req_wdata = $urandom;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (bp_hold)       rsp_ready = 1'b0;
            else if (rand_rdy) rsp_ready = ($urandom_range(0, 3) != 0);
            else               rsp_ready = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            outstanding = 0;
            held        = 1'b0;
            chk("req_ready_in_rst", 32'(req_ready), 32'd0);
            if (cyc > 0) chk("rsp_valid_in_rst", 32'(rsp_valid), 32'd0);
        end else begin
            chk("req_ready", 32'(req_ready), 32'(outstanding == 0));
            if (rsp_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rsp: got rsp_valid=1 expected 0 (cycle %0d)",
                             cyc);
                    if (rsp_ready) outstanding--;
                end else begin
                    if (!held) chk("latency", 32'(cyc), 32'(sb[0].due));
                    else begin
                        chk("hold_rdata", rsp_rdata, prev_rdata);
                        chk("hold_err", 32'(rsp_err), 32'(prev_err));
                    end
                    held       = 1'b1;
                    prev_rdata = rsp_rdata;
                    prev_err   = rsp_err;
                    if (rsp_ready) begin
                        chk("rsp_rdata", rsp_rdata, sb[0].rdata);
                        chk("rsp_err", 32'(rsp_err), 32'(sb[0].err));
                        void'(sb.pop_front());
                        held = 1'b0;
                        outstanding--;
                    end
                end
            end
            if (req_valid && req_ready) outstanding++;
        end
    end

    initial begin
        logic [31:0] a;
        logic [2:0]  f;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_rsp_rdata", rsp_rdata, 32'd0);
        chk("reset_rsp_err", 32'(rsp_err), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        issue(1, 32'h2000, 32'hDEAD_BEEF, 3'b010);
        issue(0, 32'h2000, 32'h0, 3'b010);
        issue(1, 32'h2004, 32'h1122_3344, 3'b010);
        issue(1, 32'h2005, 32'h0000_0080, 3'b000);
        issue(0, 32'h2005, 32'h0, 3'b000);
        issue(0, 32'h2005, 32'h0, 3'b100);
        issue(0, 32'h2004, 32'h0, 3'b010);
        issue(1, 32'h2006, 32'h0000_8001, 3'b001);
        issue(0, 32'h2006, 32'h0, 3'b001);
        issue(0, 32'h2006, 32'h0, 3'b101);
        issue(0, 32'h2003, 32'h0, 3'b001);
        issue(1, 32'h2002, 32'hFFFF_FFFF, 3'b010);
        issue(0, 32'h2000, 32'h0, 3'b010);
        issue(1, 32'h2FFC, 32'hCAFE_F00D, 3'b010);
        issue(0, 32'h1FFC, 32'h0, 3'b010);
        issue(0, 32'h3000, 32'h0, 3'b010);
        issue(0, 32'h2FFC, 32'h0, 3'b010);
        issue(0, 32'h2000, 32'h0, 3'b011);
        issue(1, 32'h2008, 32'h1234_5678, 3'b100);

        bp_hold = 1'b1;
        issue(0, 32'h2004, 32'h0, 3'b010);
        fork
            begin
                repeat (8) @(posedge clk);
                #2;
                bp_hold = 1'b0;
            end
        join_none
        issue(1, 32'h2008, 32'hA5A5_0F0F, 3'b010);
        issue(0, 32'h2008, 32'h0, 3'b010);

        issue(0, 32'h2000, 32'h0, 3'b010, 1'b0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        issue(1, 32'h200C, 32'h0BAD_CAFE, 3'b010);
        issue(0, 32'h200C, 32'h0, 3'b010);

        rand_rdy = 1'b1;
        for (int k = 0; k < 16; k++)
            issue(1, 32'h2000 + 32'(4*k), $urandom, 3'b010);
        for (int n = 0; n < 200; n++) begin
            case ($urandom_range(0, 7))
                0:       a = 32'h1FFC;
                1:       a = 32'h3000 + 32'($urandom_range(0, 3));
                2:       a = 32'h2FFC + 32'($urandom_range(0, 3));
                default: a = 32'h2000 + 32'($urandom_range(0, 63));
            endcase
            f = 3'($urandom_range(0, 7));
            issue(1'($urandom_range(0, 1)), a, $urandom, f);
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end

        for (int i = 0; i < 500 && (sb.size() != 0 || outstanding != 0); i++)
            @(negedge clk);
        checks++;
        if (sb.size() != 0 || outstanding != 0) begin
            errors++;
            $display("FAIL drain: got %0d responses pending expected 0",
                     sb.size());
        end
        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/rv32_dmem_responder.md
# rv32_dmem_responder

Data-memory responder: the slave end of the MEM-stage load/store request interface. Accepts one load or store per transaction from the pipeline (address from `alu_result`, store data from `mem_store_value`, width from instruction funct3). Performs the access on an internal word-organised RAM with byte enables and returns sign/zero-extended load data or a completion, with an error flag for misaligned, out-of-range or illegal-width accesses. Uses a valid/ready handshake, so the pipeline stalls MEM while the responder is busy.

## Interface
- `BASE_ADDR`, 32'h0000_2000: byte address of RAM word 0; must be 4-byte aligned.
- `DEPTH_WORDS`, 1024: RAM depth in 32-bit words; power of two, ≥ 4.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  responder can accept a request this cycle.
- `req_we`  in  1  1 = store, 0 = load.
- `req_addr`  in  32  byte address (`word_t`).
- `req_wdata`  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- `req_funct3`  in  3  access width: 000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU loads only).
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  pipeline consumes the response.
- `rsp_rdata`  out  32  load result, extended per funct3; 0 for stores and errors.
- `rsp_err`  out  1  access rejected, no RAM side effect.

## Operation
- FSM states: IDLE, READ, RESP.
- IDLE: `req_ready`=1. Handshake = `req_valid && req_ready`. On handshake, classify:
  - error if funct3 illegal (load: 011/110/111; store: anything other than 000/001/010), or H/HU with addr[0]≠0, or W with addr[1:0]≠0, or (addr − BASE_ADDR) ≥ 4·DEPTH_WORDS (unsigned, so addresses below BASE wrap and fail). Error → RESP, `rsp_err`=1, `rsp_rdata`=0, no write.
  - valid store: RAM write on the same edge; byte enables B = 1<<addr[1:0], H = 2'b11<<addr[1:0], W = 4'b1111; data replicated into lanes (B: {4{wdata[7:0]}}, H: {2{wdata[15:0]}}). → RESP, `rsp_err`=0, `rsp_rdata`=0.
  - valid load: latch word index, addr[1:0], funct3 → READ.
- READ: RAM output registered; select lane by addr[1:0]; B/H sign-extend from bit 7/15, BU/HU zero-extend, W pass-through. → RESP with `rsp_rdata` loaded.
- RESP: `rsp_valid`=1; `rsp_rdata`/`rsp_err` stable until `rsp_valid && rsp_ready`, then → IDLE. `req_ready`=0 in READ and RESP; no request accepted in the handshake cycle of a response.
- RAM contents not reset; unwritten locations read X (bench writes before reading).
- Request inputs sampled only at the handshake; changes while not ready are ignored.

## Timing
- Reset: state IDLE, `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0. `req_ready`=0 during any cycle with `rst`=1, 1 the first cycle after.
- `rst` in READ or RESP: pending response discarded, no `rsp_valid` afterwards. A store already committed stays written.
- Store/error: handshake at cycle T → `rsp_valid` high from T+1.
- Load: handshake at T → READ at T+1 → `rsp_valid` high from T+2.
- Minimum transaction period with `rsp_ready` held 1: store 2 cycles, load 3 cycles. Next handshake can occur the cycle after the response handshake.
- `rsp_ready` low holds RESP indefinitely; outputs must not glitch or change.
- `req_ready` is a decode of state only, with no combinational path from `req_valid`. `rsp_valid` is registered.

## Test plan
- Reset, then SW addr 0x2000 data 0xDEAD_BEEF → `rsp_valid` at T+1, err=0. LW 0x2000 → `rsp_rdata`=0xDEAD_BEEF at T+2.
- SB 0x2005 data 0x0000_0080, then LB 0x2005 → 0xFFFF_FF80. LBU 0x2005 → 0x0000_0080. Other bytes of word 0x2004 are unchanged after a prior SW 0x1122_3344 (LW → 0x1122_8044).
- SH 0x2006 data 0x8001, then LH 0x2006 → 0xFFFF_8001 and LHU → 0x0000_8001. LH 0x2003 → err=1, rdata=0. SW 0x2002 → err=1, and a following LW 0x2000 is unchanged.
- Range: LW 0x1FFC, LW 0x3000 (DEPTH 1024) → err=1. LW 0x2FFC → err=0. Load with funct3=011 → err=1.
- Backpressure: `rsp_ready` low for 5 cycles during a load response → `rsp_valid`/`rsp_rdata` stable, `req_ready`=0 throughout. A new `req_valid` in this window is not accepted.
- `rst` asserted in READ of a load → no response appears. `req_ready`=1 the cycle after `rst` drops, and the next SW/LW pair works normally.
